// File: rtl/reset_sequencer.sv
// Reset generator: holds all domain resets for HOLD_CYCLES, then releases domains in order every STAGGER_CYCLES.
// Re-sequences on synchronized pin reset (RELEASE/RUN) or software request (RUN only); reports cause and saturating count.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 250,
    parameter int STAGGER_CYCLES = 16,
    parameter int CNT_W          = 16,
    parameter int COUNT_W        = 8
) (
    input  logic                   io_axiClk,
    input  logic                   io_reset,
    input  logic                   io_extResetn,
    input  logic                   io_swResetReq,
    output logic [NUM_DOMAINS-1:0] io_domainResetn,
    output logic                   io_allReleased,
    output logic [1:0]             io_resetCause,
    output logic [COUNT_W-1:0]     io_resetCount,
    output logic [1:0]             io_state
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   sync1, ext_sync;
    logic                   trig_ext, trig_sw, hold_done, stag_done;
    logic [NUM_DOMAINS-1:0] rel_vec, dom_nxt;
    logic                   all_nxt;
    logic [1:0]             cause_nxt;
    logic [COUNT_W-1:0]     count_nxt;

    // Reset value 0 makes the pin look asserted until two clean edges have passed.
    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            sync1    <= 1'b0;
            ext_sync <= 1'b0;
        end else begin
            sync1    <= io_extResetn;
            ext_sync <= sync1;
        end
    end

    // Pin reset takes priority over the software request on the same edge.
    assign trig_ext  = !ext_sync && (state == ST_RELEASE || state == ST_RUN);
    assign trig_sw   = io_swResetReq && ext_sync && (state == ST_RUN);
    assign hold_done = (state == ST_HOLD) && ext_sync && (cnt == HOLD_LAST);
    assign stag_done = (state == ST_RELEASE) && (cnt == STAG_LAST);
    // Shifting a one in from the bottom guarantees in-order release.
    assign rel_vec   = (io_domainResetn << 1) | NUM_DOMAINS'(1);

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            state <= ST_ASSERT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_ASSERT: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end
            ST_HOLD: begin
                if (!ext_sync) begin
                    cnt_nxt = '0;
                end else if (hold_done) begin
                    state_nxt = rel_vec[NUM_DOMAINS-1] ? ST_RUN : ST_RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (trig_ext) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end else if (stag_done) begin
                    cnt_nxt = '0;
                    if (rel_vec[NUM_DOMAINS-1]) state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (trig_ext || trig_sw) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        dom_nxt   = io_domainResetn;
        all_nxt   = io_allReleased;
        cause_nxt = io_resetCause;
        count_nxt = io_resetCount;
        if (trig_ext || trig_sw) begin
            dom_nxt   = '0;
            all_nxt   = 1'b0;
            cause_nxt = trig_ext ? 2'd1 : 2'd2;
            if (io_resetCount != '1) count_nxt = io_resetCount + COUNT_W'(1);
        end else if (hold_done || stag_done) begin
            dom_nxt = rel_vec;
            all_nxt = rel_vec[NUM_DOMAINS-1];
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            io_domainResetn <= '0;
            io_allReleased  <= 1'b0;
            io_resetCause   <= 2'd0;
            io_resetCount   <= '0;
        end else begin
            io_domainResetn <= dom_nxt;
            io_allReleased  <= all_nxt;
            io_resetCause   <= cause_nxt;
            io_resetCount   <= count_nxt;
        end
    end

    assign io_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD=8, STAGGER=4, 4 domains, 2-bit event counter.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext;
    logic       sw;
    logic [3:0] dom;
    logic       all_rel;
    logic [1:0] cause;
    logic [1:0] count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic seen_hi;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS(4), .HOLD_CYCLES(8), .STAGGER_CYCLES(4), .CNT_W(16), .COUNT_W(2)
    ) dut (
        .io_axiClk      (clk),
        .io_reset       (rst),
        .io_extResetn   (ext),
        .io_swResetReq  (sw),
        .io_domainResetn(dom),
        .io_allReleased (all_rel),
        .io_resetCause  (cause),
        .io_resetCount  (count),
        .io_state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Leaves the bench 1 time unit after the n-th following rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input int budget);
        for (int i = 0; i < budget && state != 2'd3; i++) tick(1);
        chk("run_reached", 32'(state), 32'd3);
        chk("run_dom", 32'(dom), 32'hF);
        chk("run_all", 32'(all_rel), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        ext = 1'b1;
        sw  = 1'b0;
        tick(3);
        chk("rst_dom", 32'(dom), 32'd0);
        chk("rst_all", 32'(all_rel), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_state", 32'(state), 32'd0);

        // Power-on: domains after T0+9, +13, +17, +21.
        rst = 1'b0;
        tick(1);
        chk("po_hold", 32'(state), 32'd1);
        tick(8);
        chk("po_t8", 32'(dom), 32'h0);
        tick(1);
        chk("po_t9", 32'(dom), 32'h1);
        chk("po_t9_state", 32'(state), 32'd2);
        tick(3);
        chk("po_t12", 32'(dom), 32'h1);
        tick(1);
        chk("po_t13", 32'(dom), 32'h3);
        tick(3);
        chk("po_t16", 32'(dom), 32'h3);
        tick(1);
        chk("po_t17", 32'(dom), 32'h7);
        tick(3);
        chk("po_t20", 32'(dom), 32'h7);
        chk("po_t20_all", 32'(all_rel), 32'd0);
        tick(1);
        chk("po_t21", 32'(dom), 32'hF);
        chk("po_t21_all", 32'(all_rel), 32'd1);
        chk("po_state", 32'(state), 32'd3);
        chk("po_cause", 32'(cause), 32'd0);
        chk("po_count", 32'(count), 32'd0);

        // Pin low at edges T0+5..7: FSM sees it at T0+7..9, hold restarts at T0+10, dom0 at T0+17.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        ext = 1'b0;
        tick(3);
        ext = 1'b1;
        tick(6);
        chk("gl_t13", 32'(dom), 32'h0);
        tick(3);
        chk("gl_t16", 32'(dom), 32'h0);
        tick(1);
        chk("gl_t17", 32'(dom), 32'h1);
        tick(12);
        chk("gl_t29", 32'(dom), 32'hF);
        chk("gl_state", 32'(state), 32'd3);

        // Software reset from RUN.
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        chk("sw_dom", 32'(dom), 32'h0);
        chk("sw_all", 32'(all_rel), 32'd0);
        chk("sw_cause", 32'(cause), 32'd2);
        chk("sw_count", 32'(count), 32'd1);
        chk("sw_state", 32'(state), 32'd0);
        tick(3);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        chk("sw_ign_state", 32'(state), 32'd1);
        chk("sw_ign_count", 32'(count), 32'd1);
        tick(4);
        chk("sw_s8", 32'(dom), 32'h0);
        tick(1);
        chk("sw_s9", 32'(dom), 32'h1);
        tick(11);
        chk("sw_s20", 32'(all_rel), 32'd0);
        tick(1);
        chk("sw_s21_dom", 32'(dom), 32'hF);
        chk("sw_s21_all", 32'(all_rel), 32'd1);

        // Pin and software request on the same FSM edge (E3).
        ext = 1'b0;
        tick(2);
        chk("both_e2_state", 32'(state), 32'd3);
        sw = 1'b1;
        tick(1);
        sw  = 1'b0;
        ext = 1'b1;
        chk("both_cause", 32'(cause), 32'd1);
        chk("both_count", 32'(count), 32'd2);
        chk("both_dom", 32'(dom), 32'h0);

        // Re-sequence after E3: dom0 at E13, dom1 at E17; pin drop at E17 hits FSM at E20.
        seen_hi = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            seen_hi = seen_hi | dom[2] | dom[3];
        end
        chk("rel_e17_dom", 32'(dom), 32'h3);
        chk("rel_e17_state", 32'(state), 32'd2);
        ext = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            seen_hi = seen_hi | dom[2] | dom[3];
        end
        chk("rel_e19_dom", 32'(dom), 32'h3);
        tick(1);
        seen_hi = seen_hi | dom[2] | dom[3];
        chk("rel_e20_dom", 32'(dom), 32'h0);
        chk("rel_e20_state", 32'(state), 32'd0);
        chk("rel_e20_cause", 32'(cause), 32'd1);
        chk("rel_e20_count", 32'(count), 32'd3);
        chk("rel_no_hi", 32'(seen_hi), 32'd0);
        tick(3);
        ext = 1'b1;
        wait_run(60);

        // Counter saturation.
        for (int i = 0; i < 5; i++) begin
            sw = 1'b1;
            tick(1);
            sw = 1'b0;
            chk("sat_count", 32'(count), 32'd3);
            chk("sat_cause", 32'(cause), 32'd2);
            wait_run(40);
        end

        rst = 1'b1;
        tick(1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_cause", 32'(cause), 32'd0);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_dom", 32'(dom), 32'h0);
        chk("clr_all", 32'(all_rel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
